// File: rtl/vp_pkg.sv
// Shared vector-processor package.
// Holds the result-writer state encoding and the BRAM byte-enable patterns.
// The BRAM byte-enable patterns are shared with the fetch path, so both
// masters drive the muxed port with identical encodings.
package vp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } rw_state_t;

  localparam logic [3:0] BRAM_WE_ALL  = 4'b1111;
  localparam logic [3:0] BRAM_WE_NONE = 4'b0000;

endpackage

// File: rtl/result_writer_if.sv
// Result-vector handshake between the PE array and the result writer.
//   in_valid  producer -> writer  result vector available
//   in_ready  writer -> producer  writer accepts a vector this cycle
//   in_data   producer -> writer  element i at [i*wordSize +: wordSize]
//   in_row    producer -> writer  destination row of the vector
// master = PE array side, slave = result writer side.
interface result_writer_if #(
  parameter int NoOfElem = 16,
  parameter int wordSize = 32,
  parameter int ROWS     = 16
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [NoOfElem*wordSize-1:0] in_data;
  logic [ROW_W-1:0]             in_row;

  modport master (output in_valid, output in_data, output in_row, input in_ready);
  modport slave  (input in_valid, input in_data, input in_row, output in_ready);

endinterface

// File: rtl/result_writer.sv
// Result writer: drains one result vector per handshake into the shared BRAM,
// one word per cycle, at word address RESULT_BASE + row*NoOfElem + i, and
// raises all_done once ROWS rows have been written.
// Ports:
//   clk, RESET      clock, synchronous active-high reset
//   in_if           result-vector handshake (slave side)
//   clear           acknowledge all_done and rearm (only honoured in DONE)
//   bram_en/we      BRAM port enable and byte write enables
//   bram_addr_byte  byte address {word_addr, 2'b00}
//   bram_wdata      word being written
//   busy            high while in WRITE
//   row_done        one-cycle pulse after the last word of a row
//   all_done        level, ROWS rows written
module result_writer
  import vp_pkg::*;
#(
  parameter int                  NoOfElem    = 16,
  parameter int                  wordSize    = 32,
  parameter int                  memDepth    = 30,
  parameter int                  ROWS        = 16,
  parameter logic [memDepth-1:0] RESULT_BASE = memDepth'('h100)
) (
  input  logic                  clk,
  input  logic                  RESET,
  result_writer_if.slave        in_if,
  input  logic                  clear,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [memDepth+1:0]   bram_addr_byte,
  output logic [wordSize-1:0]   bram_wdata,
  output logic                  busy,
  output logic                  row_done,
  output logic                  all_done
);

  localparam int IDX_W  = (NoOfElem > 1) ? $clog2(NoOfElem) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int RCNT_W = $clog2(ROWS) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NoOfElem - 1);
  localparam logic [RCNT_W-1:0] ROWS_C   = RCNT_W'(ROWS);

  rw_state_t                    state;
  logic [IDX_W-1:0]             idx;
  logic [RCNT_W-1:0]            rows;
  logic [ROW_W-1:0]             row_r;
  logic [NoOfElem*wordSize-1:0] vec_r;

  logic             last_word;
  logic             job_full;
  logic             accept;
  logic [IDX_W-1:0] idx_nxt;

  // Address arithmetic is done in memDepth bits so it wraps at the top of BRAM.
  function automatic logic [memDepth-1:0] word_addr(input logic [ROW_W-1:0] row,
                                                    input logic [IDX_W-1:0] i);
    return RESULT_BASE + memDepth'(row) * memDepth'(NoOfElem) + memDepth'(i);
  endfunction

  assign last_word = (state == WRITE) && (idx == LAST_IDX);
  assign job_full  = (rows + 1'b1) == ROWS_C;
  assign idx_nxt   = idx + 1'b1;

  // Ready in IDLE, and in the final write cycle unless this row completes the job,
  // which gives zero-bubble back-to-back rows.
  assign in_if.in_ready = (state == IDLE) || (last_word && !job_full);
  assign accept         = in_if.in_valid && in_if.in_ready;
  assign busy           = (state == WRITE);

  // Capture stage: the vector is held for the whole row so the producer may move on.
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_r <= in_if.in_data;
      row_r <= in_if.in_row;
    end
  end

  // Write stage: BRAM outputs are registered one cycle ahead of the word they carry.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state          <= IDLE;
      idx            <= '0;
      rows           <= '0;
      bram_en        <= 1'b0;
      bram_we        <= BRAM_WE_NONE;
      bram_addr_byte <= '0;
      bram_wdata     <= '0;
      row_done       <= 1'b0;
      all_done       <= 1'b0;
    end else begin
      row_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state          <= WRITE;
            idx            <= '0;
            bram_en        <= 1'b1;
            bram_we        <= BRAM_WE_ALL;
            bram_addr_byte <= {word_addr(in_if.in_row, '0), 2'b00};
            bram_wdata     <= in_if.in_data[wordSize-1:0];
          end
        end
        WRITE: begin
          if (!last_word) begin
            idx            <= idx_nxt;
            bram_addr_byte <= {word_addr(row_r, idx_nxt), 2'b00};
            bram_wdata     <= vec_r[int'(idx_nxt)*wordSize +: wordSize];
          end else begin
            rows     <= rows + 1'b1;
            row_done <= 1'b1;
            if (job_full) begin
              state    <= DONE;
              all_done <= 1'b1;
              bram_en  <= 1'b0;
              bram_we  <= BRAM_WE_NONE;
            end else if (accept) begin
              idx            <= '0;
              bram_addr_byte <= {word_addr(in_if.in_row, '0), 2'b00};
              bram_wdata     <= in_if.in_data[wordSize-1:0];
            end else begin
              state   <= IDLE;
              bram_en <= 1'b0;
              bram_we <= BRAM_WE_NONE;
            end
          end
        end
        DONE: begin
          if (clear) begin
            state    <= IDLE;
            rows     <= '0;
            all_done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_writer.sv
module tb_result_writer;
  localparam int NE = 16;
  localparam int WS = 32;
  localparam int MD = 30;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic RESET;
  logic clear1, clear2;

  logic        bram_en1, bram_en2;
  logic [3:0]  bram_we1, bram_we2;
  logic [31:0] bram_addr1, bram_addr2;
  logic [31:0] bram_wdata1, bram_wdata2;
  logic        busy1, busy2, row_done1, row_done2, all_done1, all_done2;

  result_writer_if #(.NoOfElem(NE), .wordSize(WS), .ROWS(16)) if1 ();
  result_writer_if #(.NoOfElem(NE), .wordSize(WS), .ROWS(16)) if2 ();

  result_writer dut (
    .clk(clk), .RESET(RESET), .in_if(if1.slave), .clear(clear1),
    .bram_en(bram_en1), .bram_we(bram_we1), .bram_addr_byte(bram_addr1),
    .bram_wdata(bram_wdata1), .busy(busy1), .row_done(row_done1), .all_done(all_done1)
  );

  result_writer #(.RESULT_BASE(30'h3FFF_FFF8)) dut_wrap (
    .clk(clk), .RESET(RESET), .in_if(if2.slave), .clear(clear2),
    .bram_en(bram_en2), .bram_we(bram_we2), .bram_addr_byte(bram_addr2),
    .bram_wdata(bram_wdata2), .busy(busy2), .row_done(row_done2), .all_done(all_done2)
  );

  always #5 clk = ~clk;

  wr_t q1[$];
  wr_t q2[$];

  int checks = 0, errors = 0;
  int mchecks = 0, merrors = 0;

  // Scoreboard monitor for both instances: every enabled BRAM cycle pops one expectation.
  always @(negedge clk) begin
    wr_t e;
    if (bram_en1 === 1'b1) begin
      mchecks++;
      if (q1.size() == 0) begin
        merrors++;
        $display("FAIL wr_main_unexpected actual addr=%h data=%h required=no write", bram_addr1, bram_wdata1);
      end else begin
        e = q1.pop_front();
        if (bram_addr1 !== e.addr || bram_wdata1 !== e.data || bram_we1 !== 4'hF) begin
          merrors++;
          $display("FAIL wr_main actual addr=%h data=%h we=%h required addr=%h data=%h we=f",
                   bram_addr1, bram_wdata1, bram_we1, e.addr, e.data);
        end
      end
    end
    if (bram_en2 === 1'b1) begin
      mchecks++;
      if (q2.size() == 0) begin
        merrors++;
        $display("FAIL wr_wrap_unexpected actual addr=%h data=%h required=no write", bram_addr2, bram_wdata2);
      end else begin
        e = q2.pop_front();
        if (bram_addr2 !== e.addr || bram_wdata2 !== e.data || bram_we2 !== 4'hF) begin
          merrors++;
          $display("FAIL wr_wrap actual addr=%h data=%h we=%h required addr=%h data=%h we=f",
                   bram_addr2, bram_wdata2, bram_we2, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NE*WS-1:0] vec(input logic [31:0] base);
    logic [NE*WS-1:0] v;
    for (int i = 0; i < NE; i++) v[i*WS +: WS] = base + 32'(i);
    return v;
  endfunction

  // Expected writes for the default instance: word addr 'h100 + row*16 + i.
  task automatic push1(input int row, input logic [31:0] base, input int n);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = (32'h100 + 32'(row) * 32'd16 + 32'(i)) << 2;
      e.data = base + 32'(i);
      q1.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector on if1 and return just after the accepting edge.
  task automatic send_row(input int row, input logic [31:0] base, input bit hold);
    bit ok;
    ok = 1'b0;
    if1.in_row   = 4'(row);
    if1.in_data  = vec(base);
    if1.in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (if1.in_ready === 1'b1) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=not accepted required=accepted row=%0d", row);
    end
    if (!hold) if1.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 100; c++) begin
      if (q1.size() == 0 && q2.size() == 0) break;
      step();
    end
    step();
    chk({name, "_drain"}, 64'(q1.size() + q2.size()), 64'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) step();
    RESET = 1'b0;
  endtask

  initial begin
    int busy_cnt, en_cnt, rdy_cnt;
    bit got;
    wr_t e;
    RESET = 1'b1; clear1 = 1'b0; clear2 = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.in_row = '0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_row = '0;
    repeat (3) step();
    RESET = 1'b0;

    // Reset state
    chk("rst_en", 64'(bram_en1), 64'd0);
    chk("rst_we", 64'(bram_we1), 64'd0);
    chk("rst_addr", 64'(bram_addr1), 64'd0);
    chk("rst_wdata", 64'(bram_wdata1), 64'd0);
    chk("rst_busy", 64'(busy1), 64'd0);
    chk("rst_row_done", 64'(row_done1), 64'd0);
    chk("rst_all_done", 64'(all_done1), 64'd0);
    chk("rst_ready", 64'(if1.in_ready), 64'd1);

    // Test 1: row 0, data 1..16, byte addr 'h400..'h43C
    push1(0, 32'd1, 16);
    send_row(0, 32'd1, 1'b0);
    busy_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      if (k == 0) chk("t1_first_en", 64'(bram_en1), 64'd1);
      if (k == 15) chk("t1_row_done_early", 64'(row_done1), 64'd0);
      if (k == 16) chk("t1_row_done", 64'(row_done1), 64'd1);
      if (k == 17) chk("t1_row_done_pulse", 64'(row_done1), 64'd0);
      busy_cnt += int'(busy1);
      step();
    end
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd16);
    drain("t1");

    // Test 2: rows 1 and 2 back to back with in_valid held high
    push1(1, 32'h100, 16);
    push1(2, 32'h200, 16);
    send_row(1, 32'h100, 1'b1);
    if1.in_row  = 4'd2;
    if1.in_data = vec(32'h200);
    en_cnt = 0; rdy_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      en_cnt += int'(bram_en1);
      if (k < 16) rdy_cnt += int'(if1.in_ready);
      if (k == 15) chk("t2_ready_last", 64'(if1.in_ready), 64'd1);
      step();
      if (k == 15) if1.in_valid = 1'b0;
    end
    chk("t2_no_bubble", 64'(en_cnt), 64'd32);
    chk("t2_ready_cycles", 64'(rdy_cnt), 64'd1);
    drain("t2");

    // Test 3: full job of 16 rows, DONE ignores in_valid, clear rearms
    do_reset();
    for (int r = 0; r < 16; r++) begin
      push1(r, 32'(r) << 8, 16);
      send_row(r, 32'(r) << 8, 1'b0);
    end
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (all_done1 === 1'b1) begin got = 1'b1; break; end
      step();
    end
    chk("t3_all_done", 64'(got), 64'd1);
    chk("t3_ready_done", 64'(if1.in_ready), 64'd0);
    if1.in_row = 4'd9; if1.in_data = vec(32'hDEAD0000); if1.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t3_done_no_write", 64'(bram_en1), 64'd0);
      chk("t3_done_hold", 64'(all_done1), 64'd1);
    end
    clear1 = 1'b1;
    step();
    clear1 = 1'b0; if1.in_valid = 1'b0;
    chk("t3_clear_all_done", 64'(all_done1), 64'd0);
    chk("t3_clear_ready", 64'(if1.in_ready), 64'd1);
    drain("t3");

    // Test 4: reset during word 7 of row 3, then restart row 3
    push1(3, 32'h300, 8);
    send_row(3, 32'h300, 1'b0);
    repeat (7) step();
    chk("t4_idx7_en", 64'(bram_en1), 64'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("t4_rst_en", 64'(bram_en1), 64'd0);
    chk("t4_rst_we", 64'(bram_we1), 64'd0);
    chk("t4_rst_addr", 64'(bram_addr1), 64'd0);
    chk("t4_rst_wdata", 64'(bram_wdata1), 64'd0);
    chk("t4_rst_busy", 64'(busy1), 64'd0);
    chk("t4_rst_ready", 64'(if1.in_ready), 64'd1);
    chk("t4_partial_seen", 64'(q1.size()), 64'd0);
    step();
    chk("t4_no_write_after_rst", 64'(bram_en1), 64'd0);
    push1(3, 32'h3000, 16);
    send_row(3, 32'h3000, 1'b0);
    chk("t4_restart_addr", 64'(bram_addr1), 64'h4C0);
    drain("t4");

    // Test 6: in_data scrambled every cycle after acceptance
    push1(5, 32'h500, 16);
    send_row(5, 32'h500, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if1.in_data = vec(32'hBAD00000 + 32'(k * 64));
      step();
    end
    drain("t6");

    // Test 5: wrapping instance, base 2^30-8, row 0
    for (int i = 0; i < 16; i++) begin
      e.addr = 32'(((64'h3FFF_FFF8 + 64'(i)) % 64'h4000_0000) << 2);
      e.data = 32'hA0 + 32'(i);
      q2.push_back(e);
    end
    if2.in_row = 4'd0; if2.in_data = vec(32'hA0); if2.in_valid = 1'b1;
    chk("t5_ready", 64'(if2.in_ready), 64'd1);
    step();
    if2.in_valid = 1'b0;
    repeat (8) step();
    chk("t5_wrap_addr0", 64'(bram_addr2), 64'h0);
    drain("t5");

    errors += merrors;
    checks += mchecks;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
